// File: rtl/aura_i2s_tx.sv
// aura_i2s_tx: I2S / left-justified stereo serializer with a push FIFO.
// BCK comes from clk through a fractional clock-enable accumulator.
module aura_i2s_tx #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned MODE     = 1,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CEN_STEP = 768,
  parameter int unsigned CEN_LIM  = 3125,
  parameter int unsigned CNT_W    = 12
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                bck,
  output logic                lrck,
  output logic                sdata,
  output logic                underrun
);

  localparam int unsigned AW  = CNT_W + 1;
  localparam int unsigned BW  = $clog2(2 * SLOT_W);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned FW  = 2 * SAMPLE_W;
  localparam int unsigned SIW = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(2 * SLOT_W - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Clock-enable accumulator
  logic [CNT_W-1:0] r_acc;
  logic [AW-1:0]    w_acc_sum;
  logic             w_corrupt;
  logic             w_tick;

  assign w_acc_sum = {1'b0, r_acc} + AW'(CEN_STEP);
  assign w_corrupt = ({1'b0, r_acc} >= AW'(CEN_LIM + CEN_STEP));
  assign w_tick    = enable && !w_corrupt && (w_acc_sum >= AW'(CEN_LIM));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc <= '0;
    end else if (!enable || w_corrupt) begin
      r_acc <= '0;
    end else if (w_tick) begin
      r_acc <= CNT_W'(w_acc_sum - AW'(CEN_LIM));
    end else begin
      r_acc <= CNT_W'(w_acc_sum);
    end
  end

  // Sample FIFO
  logic [FW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_load;

  assign w_empty = (r_count == '0);
  assign s_ready = (r_count != (PW + 1)'(DEPTH));
  assign w_push  = s_valid && s_ready;
  assign w_pop   = w_load && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {s_left, s_right};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Serializer
  state_e         r_state, w_state_nx;
  logic [BW-1:0]  r_bitcnt, w_bitcnt_nx;
  logic [FW-1:0]  r_frame, w_frame_nx;
  logic           r_bck, w_bck_nx;
  logic           r_lrck, w_lrck_nx;
  logic           r_sdata, w_sdata_nx;
  logic           r_underrun, w_underrun_nx;
  logic           w_upd;

  always_comb begin
    w_state_nx  = r_state;
    w_bck_nx    = r_bck;
    w_bitcnt_nx = r_bitcnt;
    w_load      = 1'b0;
    w_upd       = 1'b0;
    if (!enable) begin
      w_state_nx  = StIdle;
      w_bck_nx    = 1'b0;
      w_bitcnt_nx = '0;
    end else if (w_tick) begin
      case (r_state)
        StIdle: begin
          w_state_nx  = StRun;
          w_bitcnt_nx = '0;
          w_load      = 1'b1;
          w_upd       = 1'b1;
        end
        StRun: begin
          w_bck_nx = ~r_bck;
          // Data advances only on the falling BCK tick
          if (r_bck) begin
            w_upd = 1'b1;
            if (r_bitcnt == LAST_BIT) begin
              w_bitcnt_nx = '0;
              w_load      = 1'b1;
            end else begin
              w_bitcnt_nx = r_bitcnt + 1'b1;
            end
          end
        end
        default: w_state_nx = StIdle;
      endcase
    end
  end

  logic                w_slot;
  logic [SAMPLE_W-1:0] w_word;
  int unsigned         w_pos;
  int unsigned         w_k;

  always_comb begin
    w_frame_nx = r_frame;
    if (!enable) begin
      w_frame_nx = '0;
    end else if (w_load) begin
      // No bypass: a push in this clk is not yet in the count
      w_frame_nx = w_empty ? '0 : r_mem[r_rptr];
    end
    w_slot = (w_bitcnt_nx >= BW'(SLOT_W));
    w_pos  = 32'(w_bitcnt_nx) - (w_slot ? SLOT_W : 32'd0);
    w_k    = w_pos - MODE;
    w_word = w_slot ? w_frame_nx[SAMPLE_W-1:0] : w_frame_nx[FW-1:SAMPLE_W];

    w_lrck_nx  = r_lrck;
    w_sdata_nx = r_sdata;
    if (!enable) begin
      w_lrck_nx  = 1'b0;
      w_sdata_nx = 1'b0;
    end else if (w_upd) begin
      w_lrck_nx  = w_slot;
      w_sdata_nx = (w_k < SAMPLE_W) ? w_word[SIW'(SAMPLE_W - 1 - w_k)] : 1'b0;
    end
    w_underrun_nx = w_load && w_empty;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= StIdle;
      r_bitcnt   <= '0;
      r_frame    <= '0;
      r_bck      <= 1'b0;
      r_lrck     <= 1'b0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_bitcnt   <= w_bitcnt_nx;
      r_frame    <= w_frame_nx;
      r_bck      <= w_bck_nx;
      r_lrck     <= w_lrck_nx;
      r_sdata    <= w_sdata_nx;
      r_underrun <= w_underrun_nx;
    end
  end

  assign bck      = r_bck;
  assign lrck     = r_lrck;
  assign sdata    = r_sdata;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_aura_i2s_tx.sv
// tb_aura_i2s_tx: randomized bench; every clk the pins are compared with a model
// that derives tick times, bit positions and frame contents arithmetically.
module tb_aura_i2s_tx;

  localparam int SW   = 16;
  localparam int SLOT = 18;
  localparam int MD   = 1;
  localparam int DEP  = 4;
  localparam int STEP = 3;
  localparam int LIM  = 7;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          enable;
  logic          s_valid;
  logic          s_ready;
  logic [SW-1:0] s_left;
  logic [SW-1:0] s_right;
  logic          bck;
  logic          lrck;
  logic          sdata;
  logic          underrun;

  always #5 clk = ~clk;

  aura_i2s_tx #(
    .SAMPLE_W(SW),
    .SLOT_W  (SLOT),
    .MODE    (MD),
    .DEPTH   (DEP),
    .CEN_STEP(STEP),
    .CEN_LIM (LIM),
    .CNT_W   (CW)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .enable  (enable),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_left  (s_left),
    .s_right (s_right),
    .bck     (bck),
    .lrck    (lrck),
    .sdata   (sdata),
    .underrun(underrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model state
  logic [2*SW-1:0] m_q[$];
  logic [2*SW-1:0] m_frame;
  longint          m_n;
  int              m_t;
  bit              m_bck, m_lrck, m_sdata, m_und;

  task automatic model_reset();
    m_q.delete();
    m_frame = '0;
    m_n     = 0;
    m_t     = 0;
    m_bck   = 1'b0;
    m_lrck  = 1'b0;
    m_sdata = 1'b0;
    m_und   = 1'b0;
  endtask

  task automatic check_pins(input string ph);
    check_eq({ph, "_bck"}, 32'(bck), 32'(m_bck));
    check_eq({ph, "_lrck"}, 32'(lrck), 32'(m_lrck));
    check_eq({ph, "_sdata"}, 32'(sdata), 32'(m_sdata));
    check_eq({ph, "_underrun"}, 32'(underrun), 32'(m_und));
    check_eq({ph, "_s_ready"}, 32'(s_ready), 32'(m_q.size() != DEP));
  endtask

  // Advance the model over one clk edge with the current inputs, then compare.
  task automatic step(input string ph);
    bit              ready_pre;
    bit              do_push;
    logic [2*SW-1:0] pair;
    logic [SW-1:0]   word;
    logic [SW-1:0]   sh;
    int              b, bc, k;
    ready_pre = (m_q.size() != DEP);
    do_push   = resetn && s_valid && ready_pre;
    pair      = {s_left, s_right};
    m_und     = 1'b0;
    if (!resetn) begin
      model_reset();
    end else if (!enable) begin
      m_n = 0; m_t = 0; m_bck = 0; m_lrck = 0; m_sdata = 0;
    end else begin
      m_n++;
      // A tick lands on clk n whenever floor(n*STEP/LIM) increases
      if ((m_n * STEP) / LIM != ((m_n - 1) * STEP) / LIM) begin
        m_t++;
        b     = (m_t - 1) / 2;
        bc    = b % (2 * SLOT);
        m_bck = (m_t % 2 == 0);
        if (m_t % 2 == 1) begin
          if (bc == 0) begin
            if (m_q.size() > 0) begin
              m_frame = m_q.pop_front();
            end else begin
              m_frame = '0;
              m_und   = 1'b1;
            end
          end
          m_lrck = (bc >= SLOT);
          k      = (bc % SLOT) - MD;
          word   = m_lrck ? m_frame[SW-1:0] : m_frame[2*SW-1:SW];
          m_sdata = 1'b0;
          if (k >= 0 && k < SW) begin
            sh      = word >> (SW - 1 - k);
            m_sdata = sh[0];
          end
        end
      end
    end
    if (do_push) m_q.push_back(pair);
    @(posedge clk);
    #1;
    check_pins(ph);
  endtask

  task automatic drive_rand(input int odds);
    s_valid = ($urandom_range(0, odds - 1) == 0);
    s_left  = SW'($urandom);
    s_right = SW'($urandom);
  endtask

  task automatic check_reset_now(input string ph);
    check_eq({ph, "_bck"}, 32'(bck), 32'd0);
    check_eq({ph, "_lrck"}, 32'(lrck), 32'd0);
    check_eq({ph, "_sdata"}, 32'(sdata), 32'd0);
    check_eq({ph, "_underrun"}, 32'(underrun), 32'd0);
    check_eq({ph, "_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    resetn  = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_left  = '0;
    s_right = '0;
    model_reset();
    #2;
    check_reset_now("rst0");
    repeat (2) step("rst");
    resetn = 1'b1;

    // Fill with enable low: 4 taken, the 5th and 6th refused
    for (int i = 0; i < 6; i++) begin
      drive_rand(1);
      step("fill");
    end
    s_valid = 1'b0;

    enable = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      drive_rand(200);
      step("run");
    end

    // Enable drops at random points, then a fresh frame starts
    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(20, 250)) begin
        drive_rand(60);
        step("pre_abort");
      end
      enable = 1'b0;
      repeat ($urandom_range(1, 6)) begin
        drive_rand(3);
        step("abort");
      end
      enable = 1'b1;
    end

    s_valid = 1'b0;
    repeat (500) step("starve");

    // Asynchronous reset with a loaded FIFO mid-frame
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_rand(1);
      step("refill");
    end
    s_valid = 1'b0;
    enable  = 1'b1;
    repeat ($urandom_range(60, 140)) step("pre_rst");
    resetn = 1'b0;
    #1;
    check_reset_now("async_rst");
    step("in_rst");
    resetn = 1'b1;
    for (int i = 0; i < 400; i++) begin
      drive_rand(150);
      step("post_rst");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
